boreal_ingest_sched: RTL and testbench

Read-side frame scheduler for the SPI ingestion path, in the 100 MHz system domain. Pops 792-bit payloads from the dual-clock SPI FIFO's read port and presents each one to the Active Inference logic over a valid/ready handshake, tagged with a sequence number. Supervises downstream stalls, supports a bulk flush of queued frames, and keeps delivered and dropped frame counters for host telemetry.

---
 rtl/boreal_ingest_sched.sv | 142 ++++++++++++++
 tb/tb_boreal_ingest_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_ingest_sched.sv
// boreal_ingest_sched
// Read-side frame scheduler for the SPI ingestion path (100 MHz system domain).
// Pops payloads from the dual-clock FIFO read port, presents each one downstream
// over valid/ready with a wrapping sequence tag, supervises downstream stalls,
// supports a bulk flush, and keeps saturating delivered/dropped frame counters.
//
// Ports:
//   rd_clk, rd_rst_n        clock, synchronous active-low reset
//   enable                  level; permits new pops in RUN
//   flush_req               pulse; discard held frame and everything queued
//   clr_err                 pulse; clears stall_err (a same-cycle set wins)
//   fifo_empty, fifo_dout   FIFO read-side status and head word
//   fifo_rd_en              FIFO pop (combinational)
//   m_valid, m_ready        output handshake
//   m_data, m_seq           output payload and its sequence tag
//   busy                    state != IDLE or a frame is held
//   flush_done              one-cycle pulse when a flush completes
//   stall_err               sticky downstream stall flag
//   frame_cnt, drop_cnt     saturating delivered / discarded frame counters
module boreal_ingest_sched #(
    parameter int unsigned DATA_WIDTH    = 792,
    parameter int unsigned SEQ_WIDTH     = 8,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned STALL_LIMIT   = 1024,
    parameter bit          DROP_ON_STALL = 1'b1
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  enable,
    input  logic                  flush_req,
    input  logic                  clr_err,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [SEQ_WIDTH-1:0]  m_seq,
    output logic                  busy,
    output logic                  flush_done,
    output logic                  stall_err,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam int unsigned          STALL_W   = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(STALL_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t               state, state_nxt;
    logic [SEQ_WIDTH-1:0] seq_cnt;
    logic [STALL_W-1:0]   stall_cnt;

    logic flush_start;   // flush_req accepted this cycle (ignored while flushing)
    logic load;          // pop FIFO head into the output register
    logic xfer;          // downstream transfer
    logic stalled;       // held frame not accepted this cycle
    logic stall_hit;     // stalled in the stall-limit cycle
    logic flush_pop;     // FIFO word discarded by an ongoing flush
    logic drop_evt;      // at most one drop source can be active per cycle

    always_comb begin
        state_nxt   = state;
        fifo_rd_en  = 1'b0;
        flush_done  = 1'b0;
        load        = 1'b0;
        flush_start = flush_req && (state != FLUSH);

        case (state)
            IDLE: begin
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                load       = !fifo_empty && (!m_valid || m_ready);
                fifo_rd_en = load;
                if (!enable) state_nxt = IDLE;
            end
            FLUSH: begin
                fifo_rd_en = !fifo_empty;
                if (fifo_empty) begin
                    flush_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A flush request overrides any pop, transfer or stall in its cycle.
        if (flush_start) begin
            state_nxt  = FLUSH;
            load       = 1'b0;
            fifo_rd_en = 1'b0;
        end

        xfer      = m_valid && m_ready && !flush_start;
        stalled   = m_valid && !m_ready && !flush_start;
        stall_hit = stalled && (stall_cnt == STALL_MAX);
        flush_pop = (state == FLUSH) && fifo_rd_en;
        drop_evt  = (flush_start && m_valid) || (stall_hit && DROP_ON_STALL) || flush_pop;
    end

    assign busy = (state != IDLE) || m_valid;

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state     <= IDLE;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_seq     <= '0;
            seq_cnt   <= '0;
            stall_cnt <= '0;
            stall_err <= 1'b0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            state <= state_nxt;

            if (load) begin
                m_valid <= 1'b1;
                m_data  <= fifo_dout;
                m_seq   <= seq_cnt;
            end else if (!stalled || (stall_hit && DROP_ON_STALL)) begin
                m_valid <= 1'b0;
            end

            // Flushed words still consume tags so downstream sees the gap.
            if (load || flush_pop) seq_cnt <= seq_cnt + SEQ_WIDTH'(1);

            // Without dropping, the counter parks at the limit; the flag is sticky anyway.
            if (!stalled || (stall_hit && DROP_ON_STALL)) stall_cnt <= '0;
            else if (!stall_hit)                          stall_cnt <= stall_cnt + STALL_W'(1);

            if (stall_hit)    stall_err <= 1'b1;
            else if (clr_err) stall_err <= 1'b0;

            if (xfer && (frame_cnt != '1))     frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            if (drop_evt && (drop_cnt != '1))  drop_cnt  <= drop_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_boreal_ingest_sched.sv
// tb_boreal_ingest_sched
// Self-checking bench for boreal_ingest_sched: a queue-backed FIFO feeds the DUT,
// a frame-level model predicts every output each cycle, and directed phases pin
// the model with hand-computed values (tags, counts, stall timing, flush length).
module tb_boreal_ingest_sched;

    localparam int DW    = 792;
    localparam int LIMIT = 8;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n, enable, flush_req, clr_err, fifo_empty, m_ready;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en, m_valid, busy, flush_done, stall_err;
    logic [DW-1:0] m_data;
    logic [7:0]    m_seq;
    logic [15:0]   frame_cnt, drop_cnt;

    boreal_ingest_sched #(
        .DATA_WIDTH(DW), .SEQ_WIDTH(8), .CNT_WIDTH(16),
        .STALL_LIMIT(LIMIT), .DROP_ON_STALL(1'b1)
    ) dut (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .enable(enable), .flush_req(flush_req),
        .clr_err(clr_err), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_seq(m_seq), .busy(busy), .flush_done(flush_done), .stall_err(stall_err),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    int n_pass = 0, n_total = 0;

    // External FIFO contents (head at index 0).
    logic [DW-1:0] fq[$];

    // Frame-level model: mode 0 idle, 1 running, 2 flushing.
    int            md, age;
    bit            hv, err, synced = 0;
    logic [DW-1:0] hd;
    logic [7:0]    ht, tag;
    logic [15:0]   nfr, ndr;
    int            obs_pops, obs_done;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w = '0;
        for (int i = 0; i < DW; i += 32) w = (w << 32) | DW'($urandom);
        return w;
    endfunction

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() == 0) ? '0 : fq[0];
    endtask

    // One clock cycle: compare outputs with the model, advance the model, cross the edge.
    task automatic step();
        bit            empty, flushing, xfer, take, e_rd, e_done, set_now;
        logic [DW-1:0] head;
        drive_fifo();
        #2;
        empty    = (fq.size() == 0);
        head     = empty ? '0 : fq[0];
        flushing = flush_req && (md != 2);
        e_rd     = (md == 2) ? !empty : (md == 1 && !flushing && !empty && (!hv || m_ready));
        e_done   = (md == 2) && empty;
        if (synced) begin
            check("fifo_rd_en", DW'(fifo_rd_en), DW'(e_rd));
            check("m_valid",    DW'(m_valid),    DW'(hv));
            check("m_data",     m_data,          hd);
            check("m_seq",      DW'(m_seq),      DW'(ht));
            check("busy",       DW'(busy),       DW'((md != 0) || hv));
            check("flush_done", DW'(flush_done), DW'(e_done));
            check("stall_err",  DW'(stall_err),  DW'(err));
            check("frame_cnt",  DW'(frame_cnt),  DW'(nfr));
            check("drop_cnt",   DW'(drop_cnt),   DW'(ndr));
        end
        if (fifo_rd_en === 1'b1) obs_pops++;
        if (flush_done === 1'b1) obs_done++;

        if (!rd_rst_n) begin
            md = 0; hv = 0; hd = '0; ht = '0; tag = '0; age = 0;
            nfr = '0; ndr = '0; err = 0; synced = 1;
        end else if (flushing) begin
            if (hv) ndr = sat(ndr);
            hv = 0; age = 0; md = 2;
            if (clr_err) err = 0;
        end else begin
            set_now = 0;
            xfer    = hv && m_ready;
            take    = e_rd && (md == 1);
            if (xfer) nfr = sat(nfr);
            if (md == 2) begin
                if (e_rd) begin ndr = sat(ndr); tag = tag + 8'd1; end
                if (empty) md = 0;
            end else if (md == 0) begin
                if (enable) md = 1;
            end else if (!enable) begin
                md = 0;
            end
            if (take) begin
                hv = 1; hd = head; ht = tag; tag = tag + 8'd1; age = 0;
            end else if (xfer || !hv) begin
                hv = 0; age = 0;
            end else if (age == LIMIT - 1) begin
                set_now = 1; hv = 0; ndr = sat(ndr); age = 0;
            end else begin
                age++;
            end
            if (set_now) err = 1;
            else if (clr_err) err = 0;
        end

        @(posedge rd_clk);
        #1;
        if (e_rd && fq.size() > 0) void'(fq.pop_front());
        drive_fifo();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 8 && m_valid !== 1'b1; i++) step();
        check("wait_valid", DW'(m_valid), DW'(1'b1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] words[4];
        logic [7:0]    held_tag, last_seq;
        int            k, held, cyc;
        bit            wrapped;

        rd_rst_n = 0; enable = 0; flush_req = 0; clr_err = 0; m_ready = 0;
        drive_fifo();
        step(); step();
        rd_rst_n = 1;
        check("rst_m_valid",   DW'(m_valid),   '0);
        check("rst_m_seq",     DW'(m_seq),     '0);
        check("rst_frame_cnt", DW'(frame_cnt), '0);
        check("rst_drop_cnt",  DW'(drop_cnt),  '0);
        check("rst_busy",      DW'(busy),      '0);

        // Back-to-back delivery of A..D.
        for (int i = 0; i < 4; i++) begin
            words[i] = DW'(64'hA0A0_0000_0000_0000 + 64'(i));
            fq.push_back(words[i]);
        end
        enable = 1; m_ready = 1; k = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_valid === 1'b1 && k < 4) begin
                check("b2b_data", m_data, words[k]);
                check("b2b_seq",  DW'(m_seq), DW'(k));
                k++;
            end
            step();
        end
        check("b2b_count",     DW'(k),         DW'(4));
        check("b2b_frame_cnt", DW'(frame_cnt), DW'(16'd4));

        // Stall drop: frame (tag 4) never accepted, dropped on the 8th held cycle.
        m_ready = 0;
        fq.push_back(rnd_word());
        wait_valid();
        held = 0;
        while (m_valid === 1'b1 && held < 20) begin step(); held++; end
        check("stall_held_cycles", DW'(held),      DW'(8));
        check("stall_err_set",     DW'(stall_err), DW'(1'b1));
        check("stall_drop_cnt",    DW'(drop_cnt),  DW'(16'd1));
        clr_err = 1; step(); clr_err = 0;
        check("stall_err_clr",     DW'(stall_err), DW'(1'b0));

        // Stall-boundary race: ready rises in the limit cycle (tag 5).
        fq.push_back(rnd_word());
        wait_valid();
        for (int i = 0; i < LIMIT - 1; i++) step();
        m_ready = 1; step(); m_ready = 0;
        check("race_stall_err", DW'(stall_err), DW'(1'b0));
        check("race_drop_cnt",  DW'(drop_cnt),  DW'(16'd1));
        check("race_frame_cnt", DW'(frame_cnt), DW'(16'd5));

        // Flush: one held frame (tag 6) plus five queued words.
        fq.push_back(rnd_word());
        wait_valid();
        held_tag = m_seq;
        check("flush_held_tag", DW'(held_tag), DW'(8'd6));
        for (int i = 0; i < 5; i++) fq.push_back(rnd_word());
        flush_req = 1; step(); flush_req = 0;
        obs_pops = 0; obs_done = 0; cyc = 0;
        while (obs_done == 0 && cyc < 20) begin step(); cyc++; end
        check("flush_cycles",   DW'(cyc),      DW'(6));
        check("flush_pops",     DW'(obs_pops), DW'(5));
        check("flush_drop_cnt", DW'(drop_cnt), DW'(16'd7));
        m_ready = 1;
        fq.push_back(rnd_word());
        wait_valid();
        check("flush_next_seq", DW'(m_seq), DW'(held_tag + 8'd6));

        // Sequence wrap under continuous delivery.
        for (int i = 0; i < 260; i++) fq.push_back(rnd_word());
        wrapped = 0; last_seq = '0;
        for (int i = 0; i < 400 && (fq.size() != 0 || m_valid === 1'b1); i++) begin
            if (m_valid === 1'b1) begin
                if (last_seq == 8'd255 && m_seq == 8'd0) wrapped = 1;
                last_seq = m_seq;
            end
            step();
        end
        check("seq_wrapped", DW'(wrapped), DW'(1'b1));

        // Randomized traffic with periodic backpressure bursts long enough to stall.
        for (int c = 0; c < 3000; c++) begin
            enable    = ($urandom % 8) != 0;
            m_ready   = (($urandom % 4) != 0) && !((c % 97) < 12);
            flush_req = ($urandom % 64) == 0;
            clr_err   = ($urandom % 16) == 0;
            if (fq.size() < 12 && ($urandom % 2) == 1) fq.push_back(rnd_word());
            step();
        end

        // Drain, then reset in the middle of a held frame.
        flush_req = 0; clr_err = 0; enable = 0; m_ready = 1;
        for (int i = 0; i < 20; i++) step();
        fq.delete();
        enable = 1; m_ready = 0;
        fq.push_back(rnd_word());
        wait_valid();
        rd_rst_n = 0; step(); rd_rst_n = 1;
        check("rrst_m_valid",    DW'(m_valid),    '0);
        check("rrst_m_data",     m_data,          '0);
        check("rrst_m_seq",      DW'(m_seq),      '0);
        check("rrst_stall_err",  DW'(stall_err),  '0);
        check("rrst_frame_cnt",  DW'(frame_cnt),  '0);
        check("rrst_drop_cnt",   DW'(drop_cnt),   '0);
        check("rrst_busy",       DW'(busy),       '0);
        check("rrst_fifo_rd_en", DW'(fifo_rd_en), '0);
        check("rrst_flush_done", DW'(flush_done), '0);
        enable = 0;
        for (int i = 0; i < 4; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
